// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-cache read port plus the core-side handshake.
// master = fetch stage, slave = cache/core environment.
interface if_stage_if;
  logic [31:0] iCacheReadAddr;
  logic [31:0] iCacheReadData;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] fetch_cnt;

  modport master (
    output iCacheReadAddr, instr_out, pc_out, instr_valid, fetch_cnt,
    input  iCacheReadData, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  iCacheReadAddr, instr_out, pc_out, instr_valid, fetch_cnt,
    output iCacheReadData, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one-cycle-latency cache, single-entry skid buffer, redirect flush.
// Optional macro IF_PERF_CNT_EN enables the accepted-instruction counter on fetch_cnt.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.master bus
);
  typedef enum logic [1:0] {RUN, HOLD, DRAIN, FLUSH} state_t;

  state_t      state, nextState;
  logic [31:0] fetchPc, inflightPc, skidInstr, skidPc, instrOut, pcOut;
  logic        inflightV, skidV, instrValid;
  logic        useSkid, capSkid;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= nextState;
  end

  // DRAIN/FLUSH behave like RUN with respect to a fresh stall
  always_comb begin
    nextState = state;
    if (bus.redirect_valid) nextState = FLUSH;
    else begin
      case (state)
        RUN:     nextState = bus.stall ? HOLD : RUN;
        HOLD:    if (!bus.stall) nextState = skidV ? DRAIN : RUN;
        DRAIN:   nextState = bus.stall ? HOLD : RUN;
        FLUSH:   nextState = bus.stall ? HOLD : RUN;
        default: nextState = RUN;
      endcase
    end
  end

  // The skid only ever fills on the first stall cycle, so it is only ever drained out of HOLD
  always_comb begin
    useSkid = 1'b0;
    capSkid = 1'b0;
    case (state)
      HOLD:    useSkid = skidV;
      default: capSkid = inflightV && !skidV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc    <= RESET_PC;
      inflightV  <= 1'b0;
      inflightPc <= '0;
      skidV      <= 1'b0;
      skidInstr  <= '0;
      skidPc     <= '0;
      instrValid <= 1'b0;
      instrOut   <= NOP_INSTR;
      pcOut      <= '0;
    end else if (bus.redirect_valid) begin
      fetchPc    <= bus.redirect_pc & ~32'h3;
      inflightV  <= 1'b0;
      skidV      <= 1'b0;
      instrValid <= 1'b0;
      instrOut   <= NOP_INSTR;
    end else if (bus.stall) begin
      // held address is re-issued on release, so its response is dropped
      inflightV <= 1'b0;
      if (capSkid) begin
        skidV     <= 1'b1;
        skidInstr <= bus.iCacheReadData;
        skidPc    <= inflightPc;
      end
    end else begin
      fetchPc    <= fetchPc + 32'd4;
      inflightV  <= 1'b1;
      inflightPc <= fetchPc;
      skidV      <= 1'b0;
      if (useSkid) begin
        instrValid <= 1'b1;
        instrOut   <= skidInstr;
        pcOut      <= skidPc;
      end else begin
        instrValid <= inflightV;
        instrOut   <= inflightV ? bus.iCacheReadData : NOP_INSTR;
        pcOut      <= inflightPc;
      end
    end
  end

  assign bus.iCacheReadAddr = fetchPc;
  assign bus.instr_out      = instrOut;
  assign bus.pc_out         = pcOut;
  assign bus.instr_valid    = instrValid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetchCnt;
  always_ff @(posedge clk) begin
    if (rst) fetchCnt <= '0;
    else if (instrValid && !bus.stall && !bus.redirect_valid) fetchCnt <= fetchCnt + 32'd1;
  end
  assign bus.fetch_cnt = fetchCnt;
`else
  assign bus.fetch_cnt = '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: two instances (RESET_PC 0 and FFFF_FFF8) against a
// stream-level model, directed scenarios with literal expectations, then random traffic.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redir, chkEn;
  logic [31:0] rpc;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  if_stage_if bus0();
  if_stage_if bus1();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master));
  if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master));

  assign bus0.stall = stall;
  assign bus0.redirect_valid = redir;
  assign bus0.redirect_pc = rpc;
  assign bus1.stall = stall;
  assign bus1.redirect_valid = redir;
  assign bus1.redirect_pc = rpc;

  function automatic logic [31:0] wordOf(input int i, input logic [31:0] a);
    return (i == 0) ? a : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [31:0] rpcOf(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  // cache returns the word one cycle after the address is presented
  always @(posedge clk) begin
    bus0.iCacheReadData <= wordOf(0, bus0.iCacheReadAddr);
    bus1.iCacheReadData <= wordOf(1, bus1.iCacheReadAddr);
  end

  // Stream model: after reset/redirect one extra invalid output, then consecutive
  // addresses from the start point; stall freezes everything.
  logic        mValid [2];
  logic [31:0] mPc [2], mNext [2], mCnt [2];
  int          mBub [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mValid[i] = 1'b0; mPc[i] = '0; mNext[i] = rpcOf(i); mBub[i] = 1; mCnt[i] = '0;
      end else if (redir) begin
        mValid[i] = 1'b0; mNext[i] = {rpc[31:2], 2'b00}; mBub[i] = 1;
      end else if (!stall) begin
        if (mValid[i]) mCnt[i] = mCnt[i] + 32'd1;
        if (mBub[i] > 0) begin
          mValid[i] = 1'b0; mBub[i] = mBub[i] - 1;
        end else begin
          mValid[i] = 1'b1; mPc[i] = mNext[i]; mNext[i] = mNext[i] + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [31:0] dPc [2], dInstr [2], dCnt [2];
  logic        dVal [2];
  assign dPc[0] = bus0.pc_out;         assign dPc[1] = bus1.pc_out;
  assign dInstr[0] = bus0.instr_out;   assign dInstr[1] = bus1.instr_out;
  assign dCnt[0] = bus0.fetch_cnt;     assign dCnt[1] = bus1.fetch_cnt;
  assign dVal[0] = bus0.instr_valid;   assign dVal[1] = bus1.instr_valid;

  always @(negedge clk) begin
    if (chkEn) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d.valid", i), {31'b0, dVal[i]}, {31'b0, mValid[i]});
        if (mValid[i]) begin
          chk($sformatf("m%0d.pc", i), dPc[i], mPc[i]);
          chk($sformatf("m%0d.instr", i), dInstr[i], wordOf(i, mPc[i]));
        end else begin
          chk($sformatf("m%0d.nop", i), dInstr[i], 32'h0);
        end
`ifdef IF_PERF_CNT_EN
        chk($sformatf("m%0d.cnt", i), dCnt[i], mCnt[i]);
`else
        chk($sformatf("m%0d.cnt", i), dCnt[i], 32'h0);
`endif
      end
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    stall = s; redir = r; rpc = t;
    @(negedge clk); #1;
  endtask

  task automatic expV(input string nm, input logic [31:0] pc);
    chk({nm, ".valid"}, {31'b0, bus0.instr_valid}, 32'h1);
    chk({nm, ".pc"}, bus0.pc_out, pc);
    chk({nm, ".instr"}, bus0.instr_out, pc);
  endtask

  task automatic expInv(input string nm);
    chk({nm, ".valid"}, {31'b0, bus0.instr_valid}, 32'h0);
    chk({nm, ".nop"}, bus0.instr_out, 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1; cyc(0, 0, 0); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0; chkEn = 1'b0;
    cyc(0, 0, 0);
    chkEn = 1'b1;
    cyc(0, 0, 0);
    chk("rst.valid", {31'b0, bus0.instr_valid}, 32'h0);
    chk("rst.pc", bus0.pc_out, 32'h0);
    chk("rst.instr", bus0.instr_out, 32'h0);
    chk("rst.addr0", bus0.iCacheReadAddr, 32'h0);
    chk("rst.addr1", bus1.iCacheReadAddr, 32'hFFFF_FFF8);
    chk("rst.cnt", bus0.fetch_cnt, 32'h0);
    cyc(1, 1, 32'h40);
    chk("rst.ignore", bus0.iCacheReadAddr, 32'h0);

    // reset release: first valid two cycles later, wrap on instance 1
    rst = 1'b0;
    cyc(0, 0, 0); expInv("c1");
    cyc(0, 0, 0); expV("c2", 32'h0);
    chk("wrap0", bus1.pc_out, 32'hFFFF_FFF8);
    cyc(0, 0, 0); expV("c3", 32'h4);
    chk("wrap1", bus1.pc_out, 32'hFFFF_FFFC);
    chk("wrap1.instr", bus1.instr_out, 32'hFFFF_FFFC ^ 32'h5A5A_5A5A);
    cyc(0, 0, 0); expV("c4", 32'h8);
    chk("wrap2", bus1.pc_out, 32'h0000_0000);
    cyc(0, 0, 0); expV("c5", 32'hC);

    // stall three cycles at pc 8
    doReset();
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    expV("pre", 32'h8);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0); expV("hold", 32'h8);
    end
    cyc(0, 0, 0); expV("rel0", 32'hC);
    cyc(0, 0, 0); expV("rel1", 32'h10);

    // redirect to unaligned target while pc_out=4
    doReset();
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    expV("preR", 32'h4);
    cyc(0, 1, 32'h0000_0103); expInv("r1");
    chk("r.addr", bus0.iCacheReadAddr, 32'h100);
    cyc(0, 0, 0); expInv("r2");
    cyc(0, 0, 0); expV("r3", 32'h100);
    cyc(0, 0, 0); expV("r4", 32'h104);

    // redirect wins over stall with a full skid buffer
    cyc(1, 0, 0); cyc(1, 0, 0); expV("skidHold", 32'h104);
    cyc(1, 1, 32'h2000); expInv("rs1");
    cyc(0, 0, 0); expInv("rs2");
    cyc(0, 0, 0); expV("rs3", 32'h2000);
    cyc(0, 0, 0); expV("rs4", 32'h2004);

    // reset mid-stall discards the skid
    cyc(1, 0, 0); cyc(1, 0, 0);
    rst = 1'b1; cyc(1, 0, 0); rst = 1'b0;
    cyc(0, 0, 0); expInv("rm1");
    cyc(0, 0, 0); expV("rm2", 32'h0);
    cyc(0, 0, 0); expV("rm3", 32'h4);

    // 10 accepts + 3 stalls
    doReset();
    cyc(0, 0, 0); cyc(0, 0, 0);
    for (int k = 0; k < 13; k++) cyc((k == 3 || k == 4 || k == 8), 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("cnt10", bus0.fetch_cnt, 32'd10);
`else
    chk("cnt0", bus0.fetch_cnt, 32'd0);
`endif

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic s, r;
      logic [31:0] t;
      rst = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 6);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(s, r, t);
    end
    rst = 1'b0;
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, the fetch address loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, the value driven on instr_out when no valid instruction is present.
REQ-003 Port: clk  in  1  clock, rising edge; single clock domain.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: iCacheReadAddr  out  32  fetch address to the instruction cache.
REQ-006 Port: iCacheReadData  in  32  instruction word; the cache returns the word for an address one cycle after that address is presented.
REQ-007 Port: stall  in  1  the core cannot accept an instruction this cycle.
REQ-008 Port: redirect_valid  in  1  taken branch or jump this cycle.
REQ-009 Port: redirect_pc  in  32  redirect target.
REQ-010 Port: instr_out  out  32  instruction presented to the core.
REQ-011 Port: pc_out  out  32  address of instr_out.
REQ-012 Port: instr_valid  out  1  instr_out and pc_out are valid.
REQ-013 Port: fetch_cnt  out  32  count of accepted instructions (see Configuration).

Function
REQ-014 fetch_pc register; iCacheReadAddr = fetch_pc, driven directly from the register; an address is issued every cycle.
REQ-015 In-flight tracker (inflight_v, inflight_pc) marks the response arriving next cycle; inflight_v<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32) on every cycle with rst=0, redirect_valid=0 and stall=0.
REQ-016 Single-entry skid buffer (skid_v, skid_instr, skid_pc).
REQ-017 Accept cycle (stall=0, redirect_valid=0): output register loads the skid entry if skid_v, otherwise {iCacheReadData, inflight_pc, inflight_v}; skid_v<=0.
REQ-018 Stall cycle (stall=1, redirect_valid=0): output register, fetch_pc and skid_v=1 contents hold; if inflight_v and !skid_v, the response is captured into the skid buffer; inflight_v<=0; the cache response for the held address is discarded.
REQ-019 On stall release, the skid instruction is presented first, then fetch_pc continues; there is no bubble and no duplicate or lost instruction.
REQ-020 Redirect (redirect_valid=1) overrides stall: fetch_pc<={redirect_pc[31:2],2'b00}; inflight_v, skid_v and instr_valid are cleared next cycle; the target is presented with instr_valid=1 two cycles after the redirect cycle, provided stall=0.
REQ-021 instr_out=NOP_INSTR whenever instr_valid=0.
REQ-022 FSM states: RUN (no stall, skid empty), HOLD (stall asserted), DRAIN (skid valid, stall released), FLUSH (cycle after redirect).
REQ-023 FSM transitions: RUN->HOLD on stall; HOLD->DRAIN on release with skid_v; HOLD->RUN on release with !skid_v; DRAIN->RUN; any state->FLUSH on redirect; FLUSH->RUN.
REQ-024 fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-025 While rst=1: fetch_pc=RESET_PC, inflight_v=0, skid_v=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=0, fetch_cnt=0, state=RUN; stall and redirect_valid are ignored.
REQ-026 First valid instruction (pc_out=RESET_PC) appears 2 cycles after rst falls; reset asserted mid-stall or mid-redirect discards all pending state.

Configuration
REQ-027 Macro IF_PERF_CNT_EN defined: fetch_cnt increments by 1 (wrapping) each cycle with instr_valid=1, stall=0 and redirect_valid=0.
REQ-028 Macro IF_PERF_CNT_EN undefined: the counter logic is absent and fetch_cnt is tied to 0; the port remains.

Verification
REQ-029 Reset then run with RESET_PC=0 and cache word=addr: pc_out sequence 0,4,8,12 on cycles 2,3,4,5 after reset release, with instr_out=pc_out.
REQ-030 Stall for 3 cycles while pc_out=8: outputs hold at 8; after release the sequence is 12,16 with no gap and no repeat.
REQ-031 Redirect to 32'h0000_0103 while pc_out=4: instr_valid=0 for 2 cycles, then pc_out=32'h100, then 32'h104.
REQ-032 Redirect and stall asserted in the same cycle: the redirect wins; the skid buffer is cleared; the first valid output is the target.
REQ-033 RESET_PC=32'hFFFF_FFF8: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 With IF_PERF_CNT_EN, 10 accepts and 3 stall cycles give fetch_cnt=10; without the macro, fetch_cnt=0 throughout.
